muldiv_seq_ctrl: RTL and testbench

- Multi-cycle sequencer for the EX-stage multiply/divide resource, owning the architectural HI/LO registers.
- Captures MULT/MULTU/DIV/DIVU operands and iterates a radix-2 shift-add multiplier or restoring divider over 32 cycles.
- Applies sign correction and writes HI/LO.
- Raises a stall request to the pipeline while busy. Also services single-cycle MTHI/MTLO writes.

---
 rtl/muldiv_seq_ctrl.sv | 164 ++++++++++++++++
 tb/tb_muldiv_seq_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq_ctrl.sv
// Multi-cycle multiply/divide sequencer for the EX stage; owns HI/LO.
// Radix-2 shift-add multiply and restoring divide, 32 iterations plus a sign-fix cycle.
module muldiv_seq_ctrl #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] operand_1,
  input  logic [DATA_W-1:0] operand_2,
  input  logic              cancel,
  output logic              stall_req,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_W - 1);

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  is_div_q, is_div_d;
  logic                  sign_q, sign_d;
  logic                  rsign_q, rsign_d;
  logic [DATA_W-1:0]     mcand_q, mcand_d;
  logic [DATA_W-1:0]     acc_q, acc_d;
  logic [DATA_W-1:0]     low_q, low_d;
  logic [DATA_W-1:0]     hi_q, hi_d;
  logic [DATA_W-1:0]     lo_q, lo_d;
  logic                  done_q, done_d;

  logic                  idle_issue;
  logic                  accept;
  logic                  s1, s2;
  logic [DATA_W-1:0]     mag1, mag2;
  logic [DATA_W:0]       add_sum;
  logic [DATA_W:0]       shifted;
  logic                  borrow;
  logic [DATA_W-1:0]     trial;
  logic [2*DATA_W-1:0]   product;
  logic                  div0;

  assign idle_issue = start && !cancel && (state_q == IDLE);
  assign accept     = idle_issue && !op[2];
  assign stall_req  = (state_q != IDLE) || accept;
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign hi         = hi_q;
  assign lo         = lo_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    sign_d   = sign_q;
    rsign_d  = rsign_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    low_d    = low_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    // op[0]=0 selects the signed variants of MULT and DIV.
    s1   = !op[0] && operand_1[DATA_W-1];
    s2   = !op[0] && operand_2[DATA_W-1];
    mag1 = s1 ? -operand_1 : operand_1;
    mag2 = s2 ? -operand_2 : operand_2;

    add_sum = {1'b0, acc_q} + (low_q[0] ? {1'b0, mcand_q} : '0);
    shifted = {acc_q, low_q[DATA_W-1]};
    borrow  = shifted < {1'b0, mcand_q};
    trial   = shifted[DATA_W-1:0] - mcand_q;
    product = {acc_q, low_q};
    div0    = (mcand_q == '0);

    case (state_q)
      IDLE: begin
        if (accept) begin
          is_div_d = op[1];
          sign_d   = s1 ^ s2;
          rsign_d  = s1;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = RUN;
          if (op[1]) begin
            mcand_d = mag2;
            low_d   = mag1;
          end else begin
            mcand_d = mag1;
            low_d   = mag2;
          end
        end else if (idle_issue && op == 3'b100) begin
          hi_d = operand_1;
        end else if (idle_issue && op == 3'b101) begin
          lo_d = operand_1;
        end
      end
      RUN: begin
        if (cancel) begin
          state_d = IDLE;
        end else begin
          if (is_div_q) begin
            acc_d = borrow ? shifted[DATA_W-1:0] : trial;
            low_d = {low_q[DATA_W-2:0], !borrow};
          end else begin
            acc_d = add_sum[DATA_W:1];
            low_d = {add_sum[0], low_q[DATA_W-1:1]};
          end
          if (cnt_q == CNT_MAX) state_d = FIX;
          else                  cnt_d   = cnt_q + 1'b1;
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!cancel) begin
          done_d = 1'b1;
          if (is_div_q) begin
            // Divide by zero keeps the all-ones quotient; the remainder fix restores operand_1.
            lo_d = (sign_q && !div0) ? -low_q : low_q;
            hi_d = rsign_q ? -acc_q : acc_q;
          end else begin
            {hi_d, lo_d} = sign_q ? -product : product;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      sign_q   <= 1'b0;
      rsign_q  <= 1'b0;
      mcand_q  <= '0;
      acc_q    <= '0;
      low_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      sign_q   <= sign_d;
      rsign_q  <= rsign_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      low_q    <= low_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
// Self-checking bench for muldiv_seq_ctrl: scoreboarded mul/div results,
// latency and stall timing, HI/LO moves, cancel and mid-run reset.
module tb_muldiv_seq_ctrl;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    string       name;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] operand_1 = '0;
  logic [31:0] operand_2 = '0;
  logic        cancel = 1'b0;
  logic        stall_req, busy, done;
  logic [31:0] hi, lo;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] exp_q[$];

  muldiv_seq_ctrl #(.DATA_W(32), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .operand_1(operand_1), .operand_2(operand_2), .cancel(cancel),
    .stall_req(stall_req), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Reference model for randomised operands (divisor assumed non-zero).
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sp;
    logic signed [31:0] sq, sr;
    case (o)
      3'b000: begin sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return sp; end
      3'b001: return {32'h0, a} * {32'h0, b};
      3'b010: begin sq = $signed(a) / $signed(b); sr = $signed(a) % $signed(b); return {sr, sq}; end
      default: return {a % b, a / b};
    endcase
  endfunction

  // Issue one mul/div, hold start until done, drop it in the done cycle.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, output logic [63:0] got,
                        output int lat, output int stall_errs);
    exp_q.push_back(exp);
    stall_errs = 0;
    lat = -1;
    got = '0;
    @(negedge clk);
    start = 1'b1; op = o; operand_1 = a; operand_2 = b;
    #1;
    if (stall_req !== 1'b1) stall_errs++;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = k;
        got = {hi, lo};
        start = 1'b0;
        #1;
        if (stall_req !== 1'b0) stall_errs++;
        break;
      end
      if (stall_req !== 1'b1) stall_errs++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (hi !== 32'h0)     begin n_fail++; $display("[TB] FAIL reset_hi: got %h want 0", hi); end
    n_checks++; if (lo !== 32'h0)     begin n_fail++; $display("[TB] FAIL reset_lo: got %h want 0", lo); end
    n_checks++; if (busy !== 1'b0)    begin n_fail++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0)    begin n_fail++; $display("[TB] FAIL reset_done: got %b want 0", done); end
    n_checks++; if (stall_req !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_stall: got %b want 0", stall_req); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mul;
    vec_t        v[4];
    logic [63:0] got, exp;
    int          lat, serr;
    v[0] = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, "multu_max"};
    v[1] = '{3'b000, 32'hFFFFFFFD, 32'h00000007, 64'hFFFFFFFF_FFFFFFEB, "mult_neg3x7"};
    v[2] = '{3'b000, 32'h80000000, 32'h80000000, 64'h40000000_00000000, "mult_minxmin"};
    v[3] = '{3'b000, 32'h00000006, 32'hFFFFFFFB, 64'hFFFFFFFF_FFFFFFE2, "mult_6xneg5"};
    for (int i = 0; i < 4; i++) begin
      run_op(v[i].op, v[i].a, v[i].b, v[i].exp, got, lat, serr);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
      n_checks++; if (got !== exp) begin n_fail++; $display("[TB] FAIL %s: got %h want %h", v[i].name, got, exp); end
      n_checks++; if (lat !== 34)  begin n_fail++; $display("[TB] FAIL %s_latency: got %0d want 34", v[i].name, lat); end
      n_checks++; if (serr !== 0)  begin n_fail++; $display("[TB] FAIL %s_stall: %0d bad cycles want 0", v[i].name, serr); end
    end
  endtask

  task automatic test_div;
    vec_t        v[5];
    logic [63:0] got, exp;
    int          lat, serr;
    v[0] = '{3'b010, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD, "div_neg7by2"};
    v[1] = '{3'b011, 32'h00000007, 32'h00000002, 64'h00000001_00000003, "divu_7by2"};
    v[2] = '{3'b011, 32'h00000005, 32'h00000000, 64'h00000005_FFFFFFFF, "divu_by0"};
    v[3] = '{3'b010, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, "div_min_by_m1"};
    v[4] = '{3'b010, 32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, "div_7by_neg2"};
    for (int i = 0; i < 5; i++) begin
      run_op(v[i].op, v[i].a, v[i].b, v[i].exp, got, lat, serr);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
      n_checks++; if (got !== exp) begin n_fail++; $display("[TB] FAIL %s: got %h want %h", v[i].name, got, exp); end
      n_checks++; if (lat !== 34)  begin n_fail++; $display("[TB] FAIL %s_latency: got %0d want 34", v[i].name, lat); end
      n_checks++; if (serr !== 0)  begin n_fail++; $display("[TB] FAIL %s_stall: %0d bad cycles want 0", v[i].name, serr); end
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] got, exp;
    logic [31:0] a, b;
    logic [2:0]  o;
    int          lat, serr;
    for (int i = 0; i < 8; i++) begin
      o = 3'(i % 4);
      a = $urandom;
      b = $urandom;
      if (b == 32'h0) b = 32'h3;
      if (o == 3'b010 && b == 32'hFFFFFFFF) b = 32'h5;
      run_op(o, a, b, model(o, a, b), got, lat, serr);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
      n_checks++; if (got !== exp) begin n_fail++; $display("[TB] FAIL rand_op%0d_%h_%h: got %h want %h", o, a, b, got, exp); end
      n_checks++; if (lat !== 34)  begin n_fail++; $display("[TB] FAIL rand_latency: got %0d want 34", lat); end
    end
  endtask

  task automatic test_move;
    logic stall_seen = 1'b0;
    logic done_seen  = 1'b0;
    @(negedge clk);
    start = 1'b1; op = 3'b100; operand_1 = 32'h12345678; operand_2 = 32'hDEADBEEF;
    #1; stall_seen |= stall_req;
    @(negedge clk);
    done_seen |= done;
    n_checks++; if (hi !== 32'h12345678) begin n_fail++; $display("[TB] FAIL mthi: got %h want 12345678", hi); end
    op = 3'b101; operand_1 = 32'h9ABCDEF0;
    #1; stall_seen |= stall_req;
    @(negedge clk);
    done_seen |= done;
    start = 1'b0;
    n_checks++; if (lo !== 32'h9ABCDEF0) begin n_fail++; $display("[TB] FAIL mtlo: got %h want 9abcdef0", lo); end
    n_checks++; if (hi !== 32'h12345678) begin n_fail++; $display("[TB] FAIL mtlo_hi_kept: got %h want 12345678", hi); end
    @(negedge clk);
    done_seen |= done;
    n_checks++; if (stall_seen !== 1'b0) begin n_fail++; $display("[TB] FAIL move_stall: got %b want 0", stall_seen); end
    n_checks++; if (done_seen !== 1'b0)  begin n_fail++; $display("[TB] FAIL move_done: got %b want 0", done_seen); end
  endtask

  task automatic preload;
    @(negedge clk);
    start = 1'b1; op = 3'b100; operand_1 = 32'hAAAA0000;
    @(negedge clk);
    op = 3'b101; operand_1 = 32'h00005555;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_cancel;
    logic done_seen = 1'b0;
    preload();
    n_checks++; if ({hi, lo} !== 64'hAAAA0000_00005555) begin n_fail++; $display("[TB] FAIL preload: got %h want aaaa000000005555", {hi, lo}); end
    @(negedge clk);
    start = 1'b1; op = 3'b011; operand_1 = 32'd100; operand_2 = 32'd7;
    repeat (10) @(negedge clk);
    start = 1'b0; cancel = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL cancel_busy_before: got %b want 1", busy); end
    @(negedge clk);
    cancel = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL cancel_busy_after: got %b want 0", busy); end
    for (int k = 0; k < 40; k++) begin
      done_seen |= done;
      @(negedge clk);
    end
    n_checks++; if (done_seen !== 1'b0) begin n_fail++; $display("[TB] FAIL cancel_done: got %b want 0", done_seen); end
    n_checks++; if ({hi, lo} !== 64'hAAAA0000_00005555) begin n_fail++; $display("[TB] FAIL cancel_hilo: got %h want aaaa000000005555", {hi, lo}); end
  endtask

  task automatic test_reset_abort;
    logic done_seen = 1'b0;
    preload();
    @(negedge clk);
    start = 1'b1; op = 3'b011; operand_1 = 32'd100; operand_2 = 32'd7;
    repeat (10) @(negedge clk);
    start = 1'b0; rst_n = 1'b0;
    #1;
    n_checks++; if ({hi, lo} !== 64'h0) begin n_fail++; $display("[TB] FAIL rst_abort_hilo: got %h want 0", {hi, lo}); end
    n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("[TB] FAIL rst_abort_busy: got %b want 0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      done_seen |= done | busy;
      @(negedge clk);
    end
    n_checks++; if (done_seen !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_abort_activity: got %b want 0", done_seen); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_back_to_back();
    test_move();
    test_cancel();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
